// File: rtl/etc_mode_scheduler_pkg.sv
// Shared encodings for the event-triggered sensing scheduler: FSM states,
// power-mode codes, alert levels and debug_bus field offsets.
package iah_etc_pkg;

  typedef enum logic [1:0] {
    ST_SLEEP  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ALERT  = 2'd3
  } state_t;

  localparam logic [2:0] PM_SLEEP  = 3'b001;
  localparam logic [2:0] PM_IDLE   = 3'b010;
  localparam logic [2:0] PM_ACTIVE = 3'b100;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_LOW  = 2'd1;
  localparam logic [1:0] LVL_MID  = 2'd2;
  localparam logic [1:0] LVL_HIGH = 2'd3;

  localparam int DBG_STATE_LSB = 0;
  localparam int DBG_HIT_LSB   = 2;
  localparam int DBG_QUIET_LSB = 6;
  localparam int DBG_PEND_BIT  = 14;
  localparam int DBG_OVR_BIT   = 15;
  localparam int DBG_CNT_LSB   = 16;

  // 9-bit compares so 2*thr and 1.5*thr cannot wrap for large thresholds.
  function automatic logic [1:0] score_level(input logic [7:0] score,
                                             input logic [7:0] thr);
    logic [8:0] s9, dbl, one_half;
    s9       = {1'b0, score};
    dbl      = {thr, 1'b0};
    one_half = {1'b0, thr} + {2'b00, thr[7:1]};
    if (s9 >= dbl)           return LVL_HIGH;
    else if (s9 >= one_half) return LVL_MID;
    return LVL_LOW;
  endfunction

  function automatic logic [2:0] mode_code(input state_t s);
    case (s)
      ST_SLEEP: return PM_SLEEP;
      ST_IDLE:  return PM_IDLE;
      default:  return PM_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/etc_period_timer.sv
// Down-counting sample period timer with a single-outstanding request
// handshake and a sticky overrun flag for expiries that find a request pending.
module etc_period_timer #(
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  input  logic             reload,
  input  logic             ack,
  output logic             expire,
  output logic             pending,
  output logic             overrun,
  output logic [CNT_W-1:0] count
);

  assign expire = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= CNT_W'(RST_PERIOD - 1);
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (reload || expire) count <= period - CNT_W'(1);
      else                  count <= count - CNT_W'(1);
      // An expiry that finds a request outstanding is dropped, not queued.
      if (pending) begin
        if (ack)    pending <= 1'b0;
        if (expire) overrun <= 1'b1;
      end else if (expire) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/etc_mode_scheduler.sv
// Power-mode scheduler: SLEEP/IDLE/ACTIVE/ALERT FSM driven by fused risk
// scores, with a per-mode sample period timer and alert severity tracking.
module etc_mode_scheduler
  import iah_etc_pkg::*;
#(
  parameter int SLEEP_PERIOD      = 1000,
  parameter int IDLE_PERIOD       = 100,
  parameter int ACTIVE_PERIOD     = 10,
  parameter int THRESHOLD_DEFAULT = 5,
  parameter int CONFIRM_HITS      = 3,
  parameter int QUIET_SAMPLES     = 8,
  parameter int HOLD_CYCLES       = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wake_in,
  input  logic        score_valid,
  input  logic [7:0]  score,
  input  logic [7:0]  thr_in,
  input  logic        sample_ack,
  input  logic        cancel_in,
  output logic        sample_req,
  output logic [2:0]  power_mode,
  output logic        alert_out,
  output logic [1:0]  alert_level,
  output logic [31:0] debug_bus
);

  localparam int         CW        = 16;
  localparam logic [4:0] HIT_LIM   = 5'(CONFIRM_HITS);
  localparam logic [8:0] QUIET_LIM = 9'(QUIET_SAMPLES);
  localparam logic [15:0] HOLD_LIM = 16'(HOLD_CYCLES);

  state_t        state_q, state_d;
  logic [7:0]    thr;
  logic          hit, miss, hit_done, quiet_done, changed;
  logic [3:0]    hit_q, hit_d;
  logic [7:0]    quiet_q, quiet_d;
  logic [15:0]   dwell_q, dwell_d;
  logic [1:0]    lvl_q, lvl_d, lvl_now;
  logic [2:0]    pm_q;
  logic          alert_q;
  logic [CW-1:0] period_sel, tcount;
  logic          expire, pending, overrun;
  logic [31:0]   dbg;

  assign thr        = (thr_in == 8'd0) ? 8'(THRESHOLD_DEFAULT) : thr_in;
  assign hit        = score_valid && (score >= thr);
  assign miss       = score_valid && (score < thr);
  assign hit_done   = ({1'b0, hit_q} + 5'd1) >= HIT_LIM;
  assign quiet_done = ({1'b0, quiet_q} + 9'd1) >= QUIET_LIM;
  assign lvl_now    = score_level(score, thr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SLEEP:  if (hit) state_d = ST_ACTIVE;
                 else if (wake_in) state_d = ST_IDLE;
      ST_IDLE:   if (hit) state_d = ST_ACTIVE;
                 else if (miss && quiet_done) state_d = ST_SLEEP;
      ST_ACTIVE: if (hit && hit_done) state_d = ST_ALERT;
                 else if (miss && quiet_done) state_d = ST_IDLE;
      // Scores never leave ALERT; only an accepted cancel does.
      ST_ALERT:  if (cancel_in && (dwell_q >= HOLD_LIM)) state_d = ST_IDLE;
      default:   state_d = ST_SLEEP;
    endcase
  end

  assign changed = (state_d != state_q);

  always_comb begin
    hit_d = hit_q;
    if (changed) hit_d = '0;
    else if (state_q == ST_ACTIVE && hit && hit_q != 4'hF) hit_d = hit_q + 4'd1;
    else if (state_q == ST_ACTIVE && miss) hit_d = '0;

    quiet_d = quiet_q;
    if (changed || hit) quiet_d = '0;
    else if (miss && quiet_q != 8'hFF) quiet_d = quiet_q + 8'd1;

    dwell_d = dwell_q;
    if (changed) dwell_d = '0;
    else if (state_q == ST_ALERT && dwell_q != 16'hFFFF) dwell_d = dwell_q + 16'd1;

    // Level latches on entry, then only ratchets upward while in ALERT.
    lvl_d = lvl_q;
    if (state_d != ST_ALERT) lvl_d = LVL_NONE;
    else if (state_q != ST_ALERT) lvl_d = lvl_now;
    else if (hit && lvl_now > lvl_q) lvl_d = lvl_now;

    case (state_d)
      ST_SLEEP: period_sel = CW'(SLEEP_PERIOD);
      ST_IDLE:  period_sel = CW'(IDLE_PERIOD);
      default:  period_sel = CW'(ACTIVE_PERIOD);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SLEEP;
      hit_q   <= '0;
      quiet_q <= '0;
      dwell_q <= '0;
      lvl_q   <= LVL_NONE;
      pm_q    <= PM_SLEEP;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      quiet_q <= quiet_d;
      dwell_q <= dwell_d;
      lvl_q   <= lvl_d;
      pm_q    <= mode_code(state_d);
      alert_q <= (state_d == ST_ALERT);
    end
  end

  etc_period_timer #(
    .CNT_W      (CW),
    .RST_PERIOD (SLEEP_PERIOD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .period  (period_sel),
    .reload  (changed),
    .ack     (sample_ack),
    .expire  (expire),
    .pending (pending),
    .overrun (overrun),
    .count   (tcount)
  );

  always_comb begin
    dbg = '0;
    if (!rst) begin
      dbg[DBG_STATE_LSB +: 2] = state_q;
      dbg[DBG_HIT_LSB +: 4]   = hit_q;
      dbg[DBG_QUIET_LSB +: 8] = quiet_q;
      dbg[DBG_PEND_BIT]       = pending;
      dbg[DBG_OVR_BIT]        = overrun;
      dbg[DBG_CNT_LSB +: 16]  = tcount;
    end
  end

  // Outputs are forced to their idle values for as long as rst is held.
  assign sample_req  = pending & ~rst;
  assign alert_out   = alert_q & ~rst;
  assign alert_level = rst ? LVL_NONE : lvl_q;
  assign power_mode  = rst ? PM_SLEEP : pm_q;
  assign debug_bus   = dbg;

endmodule
